rect_plotter: RTL

- Pixel-writer engine that drives the plot interface of the VGA frame-buffer adapter (x, y, colour, plot) at 160x120.
- Accepts one filled-rectangle request at a time through a valid/ready handshake.
- Emits one pixel per cycle in raster order and clips any pixel that falls off-screen.
- Used by the game controller to clear the screen and to draw paddles and the ball.

---
 rtl/rect_plotter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rect_plotter.sv
// rect_plotter: filled-rectangle pixel writer for a 160x120 frame-buffer plot port.
// Takes one request at a time over valid/ready and emits one pixel per cycle in
// raster order. Pixels that land off-screen are issued with plot low, so a request
// always takes w*h scan cycles.
module rect_plotter #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [8:0] req_x,
  input  logic [7:0] req_y,
  input  logic [7:0] req_w,
  input  logic [7:0] req_h,
  input  logic [2:0] req_colour,
  input  logic       hold,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [9:0] LP_W = 10'(SCREEN_W);
  localparam logic [8:0] LP_H = 9'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;

  // latched request
  logic [8:0] r_x0;
  logic [7:0] r_y0;
  logic [7:0] r_w;
  logic [7:0] r_h;

  // position of the pixel most recently issued
  logic [7:0] r_c;
  logic [7:0] r_r;

  // registered outputs
  logic [8:0] r_x;
  logic [7:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_busy;
  logic       r_done;
  logic       r_ready;

  // next-pixel datapath
  logic       w_c_wrap;
  logic       w_last;
  logic [7:0] w_c_nxt;
  logic [7:0] w_r_nxt;
  logic [8:0] w_base_x;
  logic [7:0] w_base_y;
  logic [7:0] w_off_c;
  logic [7:0] w_off_r;
  logic [9:0] w_px;
  logic [8:0] w_py;
  logic       w_on;

  // The first pixel is issued on the accept edge itself (straight from the request
  // inputs) so it appears on the cycle after acceptance; later pixels use the
  // latched origin plus the advanced counters.
  always_comb begin
    w_c_wrap = (r_c == r_w - 8'd1);
    w_last   = w_c_wrap && (r_r == r_h - 8'd1);
    w_c_nxt  = w_c_wrap ? '0 : r_c + 8'd1;
    w_r_nxt  = w_c_wrap ? r_r + 8'd1 : r_r;
    if (r_state == S_IDLE) begin
      w_base_x = req_x;
      w_base_y = req_y;
      w_off_c  = '0;
      w_off_r  = '0;
    end else begin
      w_base_x = r_x0;
      w_base_y = r_y0;
      w_off_c  = w_c_nxt;
      w_off_r  = w_r_nxt;
    end
    w_px = {1'b0, w_base_x} + {2'b00, w_off_c};
    w_py = {1'b0, w_base_y} + {1'b0, w_off_r};
    w_on = (w_px < LP_W) && (w_py < LP_H);
  end

  // Control FSM with registered outputs; completion is detected by comparing the
  // counters against w-1/h-1 so they never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_c      <= '0;
      r_r      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_ready) begin
            r_x0     <= req_x;
            r_y0     <= req_y;
            r_w      <= req_w;
            r_h      <= req_h;
            r_c      <= '0;
            r_r      <= '0;
            r_colour <= req_colour;
            r_x      <= w_px[8:0];
            r_y      <= w_py[7:0];
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            if (req_w == 8'd0 || req_h == 8'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_plot  <= 1'b0;
            end else begin
              r_state <= S_DRAW;
              r_plot  <= w_on;
            end
          end
        end
        S_DRAW: begin
          if (hold) begin
            r_plot <= 1'b0;
          end else if (w_last) begin
            r_plot  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_c    <= w_c_nxt;
            r_r    <= w_r_nxt;
            r_x    <= w_px[8:0];
            r_y    <= w_py[7:0];
            r_plot <= w_on;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign x         = r_x;
  assign y         = r_y;
  assign colour    = r_colour;
  assign plot      = r_plot;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
